idu_decode_stage: RTL and testbench

//  Registered RV32/RV64 instruction-decode stage between IFU and EXU. Decodes one instruction per

---
 rtl/idu_pkg.sv | 88 ++++++++
 rtl/idu_decode_stage_ctrl.sv | 141 ++++++++++++++
 rtl/idu_decode_stage.sv | 163 ++++++++++++++++
 tb/tb_idu_decode_stage.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idu_pkg.sv
// Shared decode definitions for the IDU: opcode map, control-field encodings,
// the decoded control bundle and the FSM state type.
package idu_pkg;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;
   localparam logic [6:0] OPC_FENCE   = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

   localparam logic [2:0] EXT_I = 3'b000;
   localparam logic [2:0] EXT_U = 3'b001;
   localparam logic [2:0] EXT_S = 3'b010;
   localparam logic [2:0] EXT_B = 3'b011;
   localparam logic [2:0] EXT_J = 3'b100;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_JAL  = 3'b001;
   localparam logic [2:0] BR_JALR = 3'b010;

   localparam logic [2:0] SYS_NONE   = 3'b000;
   localparam logic [2:0] SYS_ECALL  = 3'b001;
   localparam logic [2:0] SYS_EBREAK = 3'b010;
   localparam logic [2:0] SYS_MRET   = 3'b011;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_LUI  = 4'd10;   // pass operand B through

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } idu_state_e;

   // Control bundle; immediate and PC are carried separately because their width is XLEN.
   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [2:0] ext_op;
      logic       rd_en;
      logic       mem_rd;
      logic       mem_wr;
      logic [2:0] mem_op;
      logic [2:0] branch_op;
      logic [3:0] alu_ctrl;
      logic       alu_a_sel;
      logic [1:0] alu_b_sel;
      logic       mul_en;
      logic [2:0] mul_op;
      logic       csr_en;
      logic [2:0] sys_op;
      logic       illegal;
   } idu_ctrl_t;

   // ALU op from funct3; alt is inst[30], reg_op selects register-register SUB.
   function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt,
                                             input logic reg_op);
      case (f3)
         3'b000:  alu_decode = (alt & reg_op) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_decode = ALU_SLL;
         3'b010:  alu_decode = ALU_SLT;
         3'b011:  alu_decode = ALU_SLTU;
         3'b100:  alu_decode = ALU_XOR;
         3'b101:  alu_decode = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_decode = ALU_OR;
         default: alu_decode = ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/idu_decode_stage_ctrl.sv
// Combinational instruction decoder: 32-bit instruction word to control bundle
// plus sign-extended immediate.
module idu_ctrl_decode
   import idu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int EN_M     = 0,
   parameter int EN_ZICSR = 1
) (
   input  logic [31:0]     i_inst,
   output idu_ctrl_t       o_ctrl,
   output logic [XLEN-1:0] o_imm
);

   logic [6:0] w_opc;
   logic [2:0] w_f3;
   logic       w_want_rd;
   logic       w_ill;

   assign w_opc = i_inst[6:0];
   assign w_f3  = i_inst[14:12];

   // Opcode decode, then illegal masking of side-effecting enables
   always_comb begin
      o_ctrl           = '0;
      o_ctrl.rs1       = i_inst[19:15];
      o_ctrl.rs2       = i_inst[24:20];
      o_ctrl.rd        = i_inst[11:7];
      o_ctrl.alu_ctrl  = ALU_ADD;
      w_want_rd        = 1'b0;
      w_ill            = (i_inst[1:0] != 2'b11);
      case (w_opc)
         OPC_LUI: begin
            o_ctrl.ext_op   = EXT_U;
            o_ctrl.alu_ctrl = ALU_LUI;
            w_want_rd       = 1'b1;
         end
         OPC_AUIPC: begin
            o_ctrl.ext_op    = EXT_U;
            o_ctrl.alu_a_sel = 1'b1;
            w_want_rd        = 1'b1;
         end
         OPC_JAL: begin
            o_ctrl.ext_op    = EXT_J;
            o_ctrl.branch_op = BR_JAL;
            o_ctrl.alu_a_sel = 1'b1;
            o_ctrl.alu_b_sel = 2'b11;
            w_want_rd        = 1'b1;
         end
         OPC_JALR: begin
            o_ctrl.branch_op = BR_JALR;
            o_ctrl.alu_a_sel = 1'b1;
            o_ctrl.alu_b_sel = 2'b11;
            w_want_rd        = 1'b1;
         end
         OPC_BRANCH: begin
            o_ctrl.ext_op    = EXT_B;
            o_ctrl.branch_op = {1'b1, w_f3[2], w_f3[0]};
            o_ctrl.alu_b_sel = 2'b01;
            o_ctrl.alu_ctrl  = ALU_SUB;
         end
         OPC_LOAD: begin
            o_ctrl.mem_rd = 1'b1;
            o_ctrl.mem_op = w_f3;
            w_want_rd     = 1'b1;
         end
         OPC_STORE: begin
            o_ctrl.ext_op = EXT_S;
            o_ctrl.mem_wr = 1'b1;
            o_ctrl.mem_op = w_f3;
         end
         OPC_OPIMM, OPC_OPIMM32: begin
            if (w_opc == OPC_OPIMM32 && XLEN != 64) begin
               w_ill = 1'b1;
            end else begin
               o_ctrl.alu_ctrl = alu_decode(w_f3, i_inst[30], 1'b0);
               w_want_rd       = 1'b1;
            end
         end
         OPC_OP, OPC_OP32: begin
            if (w_opc == OPC_OP32 && XLEN != 64) begin
               w_ill = 1'b1;
            end else begin
               o_ctrl.alu_b_sel = 2'b01;
               if (i_inst[31:25] == 7'b0000001) begin
                  if (EN_M != 0) begin
                     o_ctrl.mul_en = 1'b1;
                     o_ctrl.mul_op = w_f3;
                     w_want_rd     = 1'b1;
                  end else begin
                     w_ill = 1'b1;
                  end
               end else begin
                  o_ctrl.alu_ctrl = alu_decode(w_f3, i_inst[30], 1'b1);
                  w_want_rd       = 1'b1;
               end
            end
         end
         OPC_FENCE: begin
         end
         OPC_SYSTEM: begin
            if (EN_ZICSR == 0) begin
               w_ill = 1'b1;
            end else if (w_f3 == 3'b000) begin
               case (i_inst[31:20])
                  12'h000: o_ctrl.sys_op = SYS_ECALL;
                  12'h001: o_ctrl.sys_op = SYS_EBREAK;
                  12'h302: o_ctrl.sys_op = SYS_MRET;
                  default: o_ctrl.sys_op = SYS_NONE;
               endcase
            end else begin
               o_ctrl.csr_en = 1'b1;
               w_want_rd     = 1'b1;
            end
         end
         default: w_ill = 1'b1;
      endcase
      o_ctrl.illegal = w_ill;
      o_ctrl.rd_en   = w_want_rd & (o_ctrl.rd != 5'd0) & ~w_ill;
      if (w_ill) begin
         o_ctrl.mem_rd = 1'b0;
         o_ctrl.mem_wr = 1'b0;
         o_ctrl.mul_en = 1'b0;
         o_ctrl.csr_en = 1'b0;
      end
   end

   // Immediate assembly; signed size casts replicate inst[31] up to XLEN
   always_comb begin
      case (o_ctrl.ext_op)
         EXT_U:   o_imm = XLEN'($signed({i_inst[31:12], 12'b0}));
         EXT_S:   o_imm = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
         EXT_B:   o_imm = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25],
                                         i_inst[11:8], 1'b0}));
         EXT_J:   o_imm = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20],
                                         i_inst[30:21], 1'b0}));
         default: o_imm = XLEN'($signed(i_inst[31:20]));
      endcase
   end

endmodule

// File: rtl/idu_decode_stage.sv
// Registered decode stage with a main entry and a one-deep skid entry. in_ready
// is registered so there is no combinational path from out_ready.
module idu_decode_stage
   import idu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int EN_M     = 0,
   parameter int EN_ZICSR = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_ext_op,
   output logic            out_rd_en,
   output logic            out_mem_rd,
   output logic            out_mem_wr,
   output logic [2:0]      out_mem_op,
   output logic [2:0]      out_branch_op,
   output logic [3:0]      out_alu_ctrl,
   output logic            out_alu_a_sel,
   output logic [1:0]      out_alu_b_sel,
   output logic            out_mul_en,
   output logic [2:0]      out_mul_op,
   output logic            out_csr_en,
   output logic [2:0]      out_sys_op,
   output logic            out_illegal
);

   idu_state_e      r_state;
   idu_state_e      w_state_nxt;
   logic            r_in_ready;
   idu_ctrl_t       w_dec_ctrl;
   logic [XLEN-1:0] w_dec_imm;
   idu_ctrl_t       r_main_ctrl, r_skid_ctrl;
   logic [XLEN-1:0] r_main_imm,  r_skid_imm;
   logic [XLEN-1:0] r_main_pc,   r_skid_pc;
   logic            w_accept;
   logic            w_load_main_in, w_load_main_skid, w_load_skid;

   idu_ctrl_decode #(
      .XLEN     (XLEN),
      .EN_M     (EN_M),
      .EN_ZICSR (EN_ZICSR)
   ) u_dec (
      .i_inst (in_inst),
      .o_ctrl (w_dec_ctrl),
      .o_imm  (w_dec_imm)
   );

   assign w_accept = in_valid & r_in_ready & ~flush;

   // Next-state and entry-load selection; flush empties the stage
   always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt    = ST_FULL;
                  w_load_main_in = 1'b1;
               end
            end
            ST_FULL: begin
               if (w_accept && out_ready) begin
                  w_load_main_in = 1'b1;
               end else if (w_accept) begin
                  w_state_nxt = ST_SKID;
                  w_load_skid = 1'b1;
               end else if (out_ready) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (out_ready) begin
                  w_state_nxt      = ST_FULL;
                  w_load_main_skid = 1'b1;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // State register and registered in_ready (low only while both entries are held)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_SKID);
      end
   end

   // Main entry: loaded from the decoder or promoted from the skid entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_ctrl <= '0;
         r_main_imm  <= '0;
         r_main_pc   <= '0;
      end else if (w_load_main_in) begin
         r_main_ctrl <= w_dec_ctrl;
         r_main_imm  <= w_dec_imm;
         r_main_pc   <= in_pc;
      end else if (w_load_main_skid) begin
         r_main_ctrl <= r_skid_ctrl;
         r_main_imm  <= r_skid_imm;
         r_main_pc   <= r_skid_pc;
      end
   end

   // Skid entry: catches the instruction accepted while the output is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_skid_ctrl <= '0;
         r_skid_imm  <= '0;
         r_skid_pc   <= '0;
      end else if (w_load_skid) begin
         r_skid_ctrl <= w_dec_ctrl;
         r_skid_imm  <= w_dec_imm;
         r_skid_pc   <= in_pc;
      end
   end

   assign in_ready      = r_in_ready;
   assign out_valid     = (r_state != ST_EMPTY);
   assign out_pc        = r_main_pc;
   assign out_imm       = r_main_imm;
   assign out_rs1       = r_main_ctrl.rs1;
   assign out_rs2       = r_main_ctrl.rs2;
   assign out_rd        = r_main_ctrl.rd;
   assign out_ext_op    = r_main_ctrl.ext_op;
   assign out_rd_en     = r_main_ctrl.rd_en;
   assign out_mem_rd    = r_main_ctrl.mem_rd;
   assign out_mem_wr    = r_main_ctrl.mem_wr;
   assign out_mem_op    = r_main_ctrl.mem_op;
   assign out_branch_op = r_main_ctrl.branch_op;
   assign out_alu_ctrl  = r_main_ctrl.alu_ctrl;
   assign out_alu_a_sel = r_main_ctrl.alu_a_sel;
   assign out_alu_b_sel = r_main_ctrl.alu_b_sel;
   assign out_mul_en    = r_main_ctrl.mul_en;
   assign out_mul_op    = r_main_ctrl.mul_op;
   assign out_csr_en    = r_main_ctrl.csr_en;
   assign out_sys_op    = r_main_ctrl.sys_op;
   assign out_illegal   = r_main_ctrl.illegal;

endmodule

// File: tb/tb_idu_decode_stage.sv
// Bench for idu_decode_stage: two configurations (RV32/EN_M=0/ZICSR=1 and
// RV64/EN_M=1/ZICSR=0) share one input stream and one in-order queue model.
module tb_idu_decode_stage;
   import idu_pkg::*;

   typedef struct packed {
      logic [63:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic [63:0] imm;
      logic [2:0]  ext;
      logic        rd_en, mem_rd, mem_wr;
      logic [2:0]  mem_op, br;
      logic [3:0]  alu;
      logic        a_sel;
      logic [1:0]  b_sel;
      logic        mul_en;
      logic [2:0]  mul_op;
      logic        csr_en;
      logic [2:0]  sys_op;
      logic        illegal;
   } exp_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] pc;
   } txn_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc;

   logic        d0_in_ready, d0_out_valid, d1_in_ready, d1_out_valid;
   logic [31:0] d0_pc, d0_imm;
   logic [63:0] d1_pc, d1_imm;
   logic [4:0]  d0_rs1, d0_rs2, d0_rd, d1_rs1, d1_rs2, d1_rd;
   logic [2:0]  d0_ext, d0_mem_op, d0_br, d0_mul_op, d0_sys_op;
   logic [2:0]  d1_ext, d1_mem_op, d1_br, d1_mul_op, d1_sys_op;
   logic        d0_rd_en, d0_mem_rd, d0_mem_wr, d0_a_sel, d0_mul_en, d0_csr_en, d0_ill;
   logic        d1_rd_en, d1_mem_rd, d1_mem_wr, d1_a_sel, d1_mul_en, d1_csr_en, d1_ill;
   logic [3:0]  d0_alu, d1_alu;
   logic [1:0]  d0_b_sel, d1_b_sel;

   idu_decode_stage #(.XLEN(32), .EN_M(0), .EN_ZICSR(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(d0_in_ready),
      .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(d0_out_valid), .out_ready(out_ready),
      .out_pc(d0_pc), .out_rs1(d0_rs1), .out_rs2(d0_rs2), .out_rd(d0_rd), .out_imm(d0_imm),
      .out_ext_op(d0_ext), .out_rd_en(d0_rd_en), .out_mem_rd(d0_mem_rd), .out_mem_wr(d0_mem_wr),
      .out_mem_op(d0_mem_op), .out_branch_op(d0_br), .out_alu_ctrl(d0_alu),
      .out_alu_a_sel(d0_a_sel), .out_alu_b_sel(d0_b_sel), .out_mul_en(d0_mul_en),
      .out_mul_op(d0_mul_op), .out_csr_en(d0_csr_en), .out_sys_op(d0_sys_op),
      .out_illegal(d0_ill));

   idu_decode_stage #(.XLEN(64), .EN_M(1), .EN_ZICSR(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(d1_in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(d1_out_valid), .out_ready(out_ready),
      .out_pc(d1_pc), .out_rs1(d1_rs1), .out_rs2(d1_rs2), .out_rd(d1_rd), .out_imm(d1_imm),
      .out_ext_op(d1_ext), .out_rd_en(d1_rd_en), .out_mem_rd(d1_mem_rd), .out_mem_wr(d1_mem_wr),
      .out_mem_op(d1_mem_op), .out_branch_op(d1_br), .out_alu_ctrl(d1_alu),
      .out_alu_a_sel(d1_a_sel), .out_alu_b_sel(d1_b_sel), .out_mul_en(d1_mul_en),
      .out_mul_op(d1_mul_op), .out_csr_en(d1_csr_en), .out_sys_op(d1_sys_op),
      .out_illegal(d1_ill));

   exp_t g0, g1;
   always_comb begin
      g0 = '{pc: {32'b0, d0_pc}, rs1: d0_rs1, rs2: d0_rs2, rd: d0_rd, imm: {32'b0, d0_imm},
             ext: d0_ext, rd_en: d0_rd_en, mem_rd: d0_mem_rd, mem_wr: d0_mem_wr,
             mem_op: d0_mem_op, br: d0_br, alu: d0_alu, a_sel: d0_a_sel, b_sel: d0_b_sel,
             mul_en: d0_mul_en, mul_op: d0_mul_op, csr_en: d0_csr_en, sys_op: d0_sys_op,
             illegal: d0_ill};
      g1 = '{pc: d1_pc, rs1: d1_rs1, rs2: d1_rs2, rd: d1_rd, imm: d1_imm,
             ext: d1_ext, rd_en: d1_rd_en, mem_rd: d1_mem_rd, mem_wr: d1_mem_wr,
             mem_op: d1_mem_op, br: d1_br, alu: d1_alu, a_sel: d1_a_sel, b_sel: d1_b_sel,
             mul_en: d1_mul_en, mul_op: d1_mul_op, csr_en: d1_csr_en, sys_op: d1_sys_op,
             illegal: d1_ill};
   end

   int   n_chk  = 0;
   int   n_fail = 0;
   txn_t q[$];
   bit   post_rst;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic alt, input bit reg_op);
      logic [3:0] tbl [8];
      tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      if (f3 == 3'd0 && reg_op && alt) return ALU_SUB;
      if (f3 == 3'd5 && alt) return ALU_SRA;
      return tbl[f3];
   endfunction

   // Reference decoder built from the instruction-set rules; immediates by plain arithmetic.
   function automatic exp_t ref_decode(input logic [31:0] inst, input int xlen,
                                       input bit en_m, input bit en_zicsr);
      exp_t e; longint v; bit want_rd, bad; logic [2:0] f3; logic [6:0] op;
      e = '0; op = inst[6:0]; f3 = inst[14:12];
      e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7];
      e.alu = ALU_ADD; want_rd = 0; bad = (inst[1:0] != 2'b11);
      case (op)
         7'h37: begin e.ext = 1; want_rd = 1; e.alu = ALU_LUI; end
         7'h17: begin e.ext = 1; want_rd = 1; e.a_sel = 1; end
         7'h6f: begin e.ext = 4; want_rd = 1; e.br = 1; e.a_sel = 1; e.b_sel = 3; end
         7'h67: begin want_rd = 1; e.br = 2; e.a_sel = 1; e.b_sel = 3; end
         7'h63: begin e.ext = 3; e.br = {1'b1, f3[2], f3[0]}; e.b_sel = 1; e.alu = ALU_SUB; end
         7'h03: begin want_rd = 1; e.mem_rd = 1; e.mem_op = f3; end
         7'h23: begin e.ext = 2; e.mem_wr = 1; e.mem_op = f3; end
         7'h13, 7'h1b:
            if (op == 7'h1b && xlen != 64) bad = 1;
            else begin want_rd = 1; e.alu = alu_ref(f3, inst[30], 0); end
         7'h33, 7'h3b:
            if (op == 7'h3b && xlen != 64) bad = 1;
            else begin
               e.b_sel = 1;
               if (inst[31:25] == 7'd1) begin
                  if (en_m) begin e.mul_en = 1; e.mul_op = f3; want_rd = 1; end
                  else bad = 1;
               end else begin
                  want_rd = 1; e.alu = alu_ref(f3, inst[30], 1);
               end
            end
         7'h0f: ;
         7'h73:
            if (!en_zicsr) bad = 1;
            else if (f3 == 0) begin
               if (inst[31:20] == 12'h000) e.sys_op = 1;
               else if (inst[31:20] == 12'h001) e.sys_op = 2;
               else if (inst[31:20] == 12'h302) e.sys_op = 3;
            end else begin e.csr_en = 1; want_rd = 1; end
         default: bad = 1;
      endcase
      case (e.ext)
         3'd1: begin v = longint'(inst[31:12]) * 4096; if (inst[31]) v -= (longint'(1) << 32); end
         3'd2: begin v = longint'({inst[31:25], inst[11:7]}); if (inst[31]) v -= 4096; end
         3'd3: begin
            v = inst[31] * 4096 + inst[7] * 2048 + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
            if (inst[31]) v -= 8192;
         end
         3'd4: begin
            v = inst[31] * (1 << 20) + longint'(inst[19:12]) * 4096 + inst[20] * 2048
                + longint'(inst[30:21]) * 2;
            if (inst[31]) v -= (1 << 21);
         end
         default: begin v = longint'(inst[31:20]); if (inst[31]) v -= 4096; end
      endcase
      e.imm = (xlen == 64) ? v : (v & 64'hFFFF_FFFF);
      if (bad) begin e.mem_rd = 0; e.mem_wr = 0; e.mul_en = 0; e.csr_en = 0; end
      e.rd_en = want_rd && !bad && (e.rd != 0);
      e.illegal = bad;
      return e;
   endfunction

   task automatic compare_dut(input string p, input exp_t g, input logic gv, input logic gr,
                              input int xlen, input bit en_m, input bit en_z);
      exp_t e;
      check_eq({p, ".in_ready"}, gr, rst_n && !post_rst && q.size() < 2);
      check_eq({p, ".out_valid"}, gv, q.size() > 0);
      if (q.size() > 0) begin
         e = ref_decode(q[0].inst, xlen, en_m, en_z);
         check_eq({p, ".pc"}, g.pc, (xlen == 64) ? q[0].pc : (q[0].pc & 64'hFFFF_FFFF));
         check_eq({p, ".rs1"}, g.rs1, e.rs1);         check_eq({p, ".rs2"}, g.rs2, e.rs2);
         check_eq({p, ".rd"}, g.rd, e.rd);            check_eq({p, ".imm"}, g.imm, e.imm);
         check_eq({p, ".ext_op"}, g.ext, e.ext);      check_eq({p, ".rd_en"}, g.rd_en, e.rd_en);
         check_eq({p, ".mem_rd"}, g.mem_rd, e.mem_rd); check_eq({p, ".mem_wr"}, g.mem_wr, e.mem_wr);
         check_eq({p, ".mem_op"}, g.mem_op, e.mem_op); check_eq({p, ".branch_op"}, g.br, e.br);
         check_eq({p, ".alu_ctrl"}, g.alu, e.alu);    check_eq({p, ".a_sel"}, g.a_sel, e.a_sel);
         check_eq({p, ".b_sel"}, g.b_sel, e.b_sel);   check_eq({p, ".mul_en"}, g.mul_en, e.mul_en);
         check_eq({p, ".mul_op"}, g.mul_op, e.mul_op); check_eq({p, ".csr_en"}, g.csr_en, e.csr_en);
         check_eq({p, ".sys_op"}, g.sys_op, e.sys_op); check_eq({p, ".illegal"}, g.illegal, e.illegal);
      end
   endtask

   // One clock: update the queue model with the inputs seen at the edge, then compare.
   task automatic cycle();
      bit acc;
      @(posedge clk);
      if (!rst_n || flush) begin
         q.delete();
         if (!rst_n) post_rst = 1;
         else post_rst = 0;
      end else begin
         acc = in_valid && !post_rst && (q.size() < 2);
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (acc) q.push_back('{inst: in_inst, pc: in_pc});
         post_rst = 0;
      end
      @(negedge clk);
      compare_dut("d0", g0, d0_out_valid, d0_in_ready, 32, 0, 1);
      compare_dut("d1", g1, d1_out_valid, d1_in_ready, 64, 1, 0);
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                        input logic ordy);
      in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 17))
         0: w[6:0] = 7'h37;   1: w[6:0] = 7'h17;   2: w[6:0] = 7'h6f;
         3: w[6:0] = 7'h67;   4: w[6:0] = 7'h63;   5: w[6:0] = 7'h03;
         6: w[6:0] = 7'h23;   7, 8: w[6:0] = 7'h13; 9: w[6:0] = 7'h1b;
         10, 11: w[6:0] = 7'h33; 12: w[6:0] = 7'h3b; 13: w[6:0] = 7'h0f;
         14: begin w[6:0] = 7'h33; w[31:25] = 7'b0000001; end
         15: begin
            w[6:0] = 7'h73;
            if ($urandom_range(0, 1) == 1) begin
               w[14:12] = 3'b000;
               case ($urandom_range(0, 3))
                  0: w[31:20] = 12'h000;
                  1: w[31:20] = 12'h001;
                  2: w[31:20] = 12'h302;
                  default: ;
               endcase
            end
         end
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      rst_n = 0; flush = 0; post_rst = 1;
      drive(0, 32'h0, 64'h0, 0);
      #1;
      check_eq("rst.d0_out_valid", d0_out_valid, 0);
      check_eq("rst.d0_in_ready", d0_in_ready, 0);
      check_eq("rst.d0_imm", d0_imm, 0);
      check_eq("rst.d1_rd_en", d1_rd_en, 0);
      cycle(); cycle();
      rst_n = 1;
      cycle();
      check_eq("rst.in_ready_after", d0_in_ready, 1);

      // addi x1,x0,5
      drive(1, 32'h00500093, 64'h8000_0000, 1);
      cycle();
      check_eq("t1.valid", d0_out_valid, 1);  check_eq("t1.rd", d0_rd, 1);
      check_eq("t1.imm", d0_imm, 5);          check_eq("t1.ext", d0_ext, 0);
      check_eq("t1.rd_en", d0_rd_en, 1);      check_eq("t1.b_sel", d0_b_sel, 0);
      check_eq("t1.illegal", d0_ill, 0);      check_eq("t1.pc", d0_pc, 32'h8000_0000);

      // jal x1,8
      drive(1, 32'h008000EF, 64'h8000_0004, 1);
      cycle();
      check_eq("t2.ext", d0_ext, 4);          check_eq("t2.imm", d0_imm, 8);
      check_eq("t2.br", d0_br, 1);            check_eq("t2.a_sel", d0_a_sel, 1);
      check_eq("t2.b_sel", d0_b_sel, 3);      check_eq("t2.rd_en", d0_rd_en, 1);
      drive(0, 32'h0, 64'h0, 1);
      cycle();

      // A,B,C under backpressure, then drain in order
      drive(1, 32'h00100113, 64'h100, 0); cycle();
      drive(1, 32'h00200193, 64'h104, 0); cycle();
      check_eq("t3.in_ready_lo", d0_in_ready, 0);
      drive(1, 32'h00300213, 64'h108, 0); cycle();
      check_eq("t3.hold_pc", d0_pc, 32'h100);
      check_eq("t3.in_ready_hold", d0_in_ready, 0);
      out_ready = 1; cycle();
      check_eq("t3.pcB", d0_pc, 32'h104);     check_eq("t3.vB", d0_out_valid, 1);
      cycle();
      check_eq("t3.pcC", d0_pc, 32'h108);     check_eq("t3.vC", d0_out_valid, 1);
      drive(0, 32'h0, 64'h0, 1); cycle();

      // flush in SKID with D presented
      drive(1, 32'h00100113, 64'h200, 0); cycle();
      drive(1, 32'h00200193, 64'h204, 0); cycle();
      flush = 1; drive(1, 32'h00400293, 64'h208, 0); cycle();
      flush = 0;
      check_eq("t4.valid", d0_out_valid, 0);  check_eq("t4.in_ready", d0_in_ready, 1);
      drive(0, 32'h0, 64'h0, 1); cycle();
      check_eq("t4.no_D", d0_out_valid, 0);

      // mul x0,x1,x2 on both configurations
      drive(1, 32'h02208033, 64'h300, 1); cycle();
      check_eq("t5.d0_illegal", d0_ill, 1);   check_eq("t5.d0_mul_en", d0_mul_en, 0);
      check_eq("t5.d1_mul_en", d1_mul_en, 1); check_eq("t5.d1_mul_op", d1_mul_op, 0);
      check_eq("t5.d1_rd_en", d1_rd_en, 0);   check_eq("t5.d1_illegal", d1_ill, 0);

      // ecall and all-ones
      drive(1, 32'h00000073, 64'h304, 1); cycle();
      check_eq("t6.d0_sys", d0_sys_op, 1);    check_eq("t6.d1_sys_ill", d1_ill, 1);
      drive(1, 32'hFFFFFFFF, 64'h308, 1); cycle();
      check_eq("t6.d0_ill", d0_ill, 1);       check_eq("t6.d1_ill", d1_ill, 1);

      // reset while FULL
      drive(1, 32'h00500093, 64'h400, 0); cycle();
      drive(0, 32'h0, 64'h0, 0); cycle();
      check_eq("t6.full", d0_out_valid, 1);
      #2 rst_n = 0;
      #1;
      check_eq("t6.rst_d0_valid", d0_out_valid, 0);
      check_eq("t6.rst_d1_valid", d1_out_valid, 0);
      q.delete(); post_rst = 1;
      cycle();
      rst_n = 1;
      cycle();
      check_eq("t6.in_ready_rel", d0_in_ready, 1);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         in_inst   = rand_inst();
         in_pc     = {32'($urandom), 32'($urandom)};
         in_pc[1:0] = 2'b00;
         cycle();
      end
      flush = 0;
      drive(0, 32'h0, 64'h0, 1);
      cycle(); cycle(); cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
